// File: rtl/hs_burst_receiver.sv
// Four-phase Req/Ack burst receiver writing each word to a memory write port (one write per handshake), auto-incrementing the address.
// All outputs registered: Req sampled at edge N gives WriteEnable/Ack after edge N; Ready pulses READY_CYCLES cycles at burst end.
// Optional stall watchdog: define HS_BURST_RECEIVER_TIMEOUT_EN (otherwise a stalled burst waits indefinitely and Error stays 0).
module hs_burst_receiver #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 4,
    parameter int READY_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              Clock_i,
    input  logic              ResetN_i,
    input  logic              Req_i,
    input  logic [DATA_W-1:0] Entrada_i,
    input  logic [ADDR_W-1:0] BaseAddr_i,
    input  logic [ADDR_W-1:0] Length_i,
    output logic              Ack_o,
    output logic [DATA_W-1:0] DataIn_o,
    output logic [ADDR_W-1:0] Address_o,
    output logic              WriteEnable_o,
    output logic              Busy_o,
    output logic              Ready_o,
    output logic              Error_o,
    output logic [ADDR_W:0]   WordCount_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_ACK_HOLD, S_WAIT_REQ, S_DONE, S_ERROR
    } state_t;

    localparam int RC_W = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rdy_cnt_q, rdy_cnt_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

`ifdef HS_BURST_RECEIVER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] stall_q, stall_d;
    logic            err_q, err_d;
    logic            stalling;
    logic            timeout_hit;

    assign stalling    = ((state_q == S_ACK_HOLD) && Req_i) ||
                         ((state_q == S_WAIT_REQ) && !Req_i);
    assign timeout_hit = stalling && (stall_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // State register
    always_ff @(posedge Clock_i or negedge ResetN_i) begin
        if (!ResetN_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (Req_i) state_d = S_CAPTURE;
            S_CAPTURE:  state_d = S_ACK_HOLD;
            S_ACK_HOLD: begin
                if (!Req_i) state_d = (wc_q == len_q) ? S_DONE : S_WAIT_REQ;
`ifdef HS_BURST_RECEIVER_TIMEOUT_EN
                else if (timeout_hit) state_d = S_ERROR;
`endif
            end
            S_WAIT_REQ: begin
                if (Req_i) state_d = S_CAPTURE;
`ifdef HS_BURST_RECEIVER_TIMEOUT_EN
                else if (timeout_hit) state_d = S_ERROR;
`endif
            end
            S_DONE:     if (rdy_cnt_q == RC_W'(READY_CYCLES - 1)) state_d = S_IDLE;
`ifdef HS_BURST_RECEIVER_TIMEOUT_EN
            S_ERROR:    state_d = S_IDLE;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        cnt_d     = cnt_q;
        len_d     = len_q;
        wc_d      = wc_q;
        data_d    = data_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        ack_d     = ack_q;
        rdy_cnt_d = (state_q == S_DONE) ? rdy_cnt_q + RC_W'(1) : '0;
        case (state_q)
            S_IDLE: begin
                if (Req_i) begin
                    cnt_d  = BaseAddr_i;
                    len_d  = (Length_i == '0) ? DEPTH : {1'b0, Length_i};
                    wc_d   = '0;
                    data_d = Entrada_i;
                    addr_d = BaseAddr_i;
                    we_d   = 1'b1;
                    ack_d  = 1'b1;
                end
            end
            S_CAPTURE: begin
                wc_d  = wc_q + (ADDR_W+1)'(1);
                cnt_d = cnt_q + ADDR_W'(1);
            end
            S_ACK_HOLD: if (!Req_i) ack_d = 1'b0;
            S_WAIT_REQ: begin
                if (Req_i) begin
                    data_d = Entrada_i;
                    addr_d = cnt_q;
                    we_d   = 1'b1;
                    ack_d  = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef HS_BURST_RECEIVER_TIMEOUT_EN
        err_d   = err_q;
        stall_d = (state_d != state_q) ? '0 : (stalling ? stall_q + TO_W'(1) : stall_q);
        if ((state_q == S_IDLE) && Req_i) err_d = 1'b0;
        if (state_d == S_ERROR) begin
            ack_d = 1'b0;
            we_d  = 1'b0;
            err_d = 1'b1;
        end
`endif
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clock_i or negedge ResetN_i) begin
        if (!ResetN_i) begin
            rdy_cnt_q <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            wc_q      <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            rdy_cnt_q <= rdy_cnt_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            wc_q      <= wc_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

`ifdef HS_BURST_RECEIVER_TIMEOUT_EN
    always_ff @(posedge Clock_i or negedge ResetN_i) begin
        if (!ResetN_i) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
    assign Error_o = err_q;
`else
    assign Error_o = 1'b0;
`endif

    assign Ack_o         = ack_q;
    assign DataIn_o      = data_q;
    assign Address_o     = addr_q;
    assign WriteEnable_o = we_q;
    assign Busy_o        = busy_q;
    assign Ready_o       = ready_q;
    assign WordCount_o   = wc_q;

endmodule
